stream_pattern_gen: RTL and testbench

Parametrised AXI-Stream-style pattern source, the next-generation successor to the team's 8-bit incrementing `generator`. It emits bursts of configurable length in one of four pattern modes: counter with step, Galois LFSR, walking-one and constant. Each burst ends with `last`, and an optional idle gap separates bursts. It sits at the head of the lab datapath, feeding downstream stream consumers and checkers through a valid/ready handshake.

---
 rtl/pattern_pkg.sv | 17 +
 rtl/pattern_step.sv | 38 +++
 rtl/stream_pattern_gen.sv | 121 ++++++++++++
 tb/tb_stream_pattern_gen.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pattern_pkg.sv
// Shared definitions for the stream pattern source: pattern modes and FSM state encoding.
package pattern_pkg;

   typedef enum logic [1:0] {
      MODE_COUNT = 2'd0,
      MODE_LFSR  = 2'd1,
      MODE_WALK  = 2'd2,
      MODE_CONST = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      GAP  = 2'd2
   } state_e;

endpackage

// File: rtl/pattern_step.sv
// Combinational pattern arithmetic: the first value of a burst and the value following a beat.
module pattern_step
   import pattern_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  mode_e                  mode,
   input  logic [DATA_WIDTH-1:0]  value,
   input  logic [DATA_WIDTH-1:0]  step,
   input  logic [DATA_WIDTH-1:0]  taps,
   input  mode_e                  start_mode,
   input  logic [DATA_WIDTH-1:0]  seed,
   output logic [DATA_WIDTH-1:0]  next_value,
   output logic [DATA_WIDTH-1:0]  first_value
);

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
      next_value = value;
      case (mode)
         MODE_COUNT: next_value = value + step;
         MODE_LFSR:  next_value = (value >> 1) ^ (value[0] ? taps : '0);
         MODE_WALK:  next_value = {value[DATA_WIDTH-2:0], value[DATA_WIDTH-1]};
         default:    next_value = value;
      endcase
   end

   always_comb begin
      first_value = seed;
      case (start_mode)
         // An all-zero Galois LFSR never leaves zero, so substitute 1.
         MODE_LFSR: if (seed == '0) first_value = DATA_WIDTH'(1);
         MODE_WALK: first_value = DATA_WIDTH'(1);
         default:   first_value = seed;
      endcase
   end

endmodule

// File: rtl/stream_pattern_gen.sv
// Valid/ready burst pattern source: FSM, beat and gap counters, output registers.
module stream_pattern_gen
   import pattern_pkg::*;
#(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    LEN_WIDTH  = 8,
   parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = DATA_WIDTH'(8'hB8),
   parameter int                    GAP_CYCLES = 0
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic                  enable,
   input  logic [1:0]            mode,
   input  logic [DATA_WIDTH-1:0] seed,
   input  logic [DATA_WIDTH-1:0] step,
   input  logic [LEN_WIDTH-1:0]  burst_len,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid,
   input  logic                  ready,
   output logic                  last,
   output logic                  busy
);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   state_e                  state_q, state_d;
   mode_e                   mode_q, mode_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic [DATA_WIDTH-1:0]   step_q, step_d;
   logic [LEN_WIDTH-1:0]    len_q, len_d;
   logic [LEN_WIDTH-1:0]    beat_q, beat_d;
   logic [GAP_W-1:0]        gap_q, gap_d;
   logic [DATA_WIDTH-1:0]   next_value, first_value;
   logic                    start;

   pattern_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
      .mode        (mode_q),
      .value       (data_q),
      .step        (step_q),
      .taps        (LFSR_TAPS),
      .start_mode  (mode_e'(mode)),
      .seed        (seed),
      .next_value  (next_value),
      .first_value (first_value)
   );

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      data_d  = data_q;
      step_d  = step_q;
      len_d   = len_q;
      beat_d  = beat_q;
      gap_d   = gap_q;
      start   = 1'b0;

      case (state_q)
         IDLE: start = enable;
         RUN: begin
            // valid is implied by RUN, so ready alone marks an accepted beat.
            if (ready) begin
               if (beat_q == len_q) begin
                  if (GAP_CYCLES > 0) begin
                     state_d = GAP;
                     gap_d   = '0;
                  end else if (enable) begin
                     start = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  data_d = next_value;
                  beat_d = beat_q + LEN_WIDTH'(1);
               end
            end
         end
         GAP: begin
            if (gap_q == GAP_LAST) state_d = IDLE;
            else                   gap_d   = gap_q + GAP_W'(1);
         end
         default: state_d = IDLE;
      endcase

      if (start) begin
         state_d = RUN;
         mode_d  = mode_e'(mode);
         step_d  = step;
         len_d   = burst_len;
         data_d  = first_value;
         beat_d  = '0;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q <= IDLE;
         mode_q  <= MODE_COUNT;
         data_q  <= '0;
         step_q  <= '0;
         len_q   <= '0;
         beat_q  <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         data_q  <= data_d;
         step_q  <= step_d;
         len_q   <= len_d;
         beat_q  <= beat_d;
         gap_q   <= gap_d;
      end
   end

   assign data_out = data_q;
   assign valid    = (state_q == RUN);
   assign last     = (state_q == RUN) && (beat_q == len_q);
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_stream_pattern_gen.sv
// Self-checking bench: one instance without idle gap, one with a 3-cycle gap, shared stimulus.
module tb_stream_pattern_gen;

   logic       aclk = 1'b0;
   logic       areset;
   logic       enable;
   logic [1:0] mode;
   logic [7:0] seed;
   logic [7:0] step;
   logic [7:0] burst_len;
   logic       ready;

   logic [7:0] data0, data3;
   logic       valid0, valid3, last0, last3, busy0, busy3;

   int checks   = 0;
   int failures = 0;

   always #5 aclk = ~aclk;

   stream_pattern_gen #(.DATA_WIDTH(8), .LEN_WIDTH(8), .LFSR_TAPS(8'hB8), .GAP_CYCLES(0)) u_gap0 (
      .aclk(aclk), .areset(areset), .enable(enable), .mode(mode), .seed(seed), .step(step),
      .burst_len(burst_len), .data_out(data0), .valid(valid0), .ready(ready), .last(last0), .busy(busy0)
   );

   stream_pattern_gen #(.DATA_WIDTH(8), .LEN_WIDTH(8), .LFSR_TAPS(8'hB8), .GAP_CYCLES(3)) u_gap3 (
      .aclk(aclk), .areset(areset), .enable(enable), .mode(mode), .seed(seed), .step(step),
      .burst_len(burst_len), .data_out(data3), .valid(valid3), .ready(ready), .last(last3), .busy(busy3)
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic timeout_fail(input string tag);
      checks++;
      failures++;
      $error("FAIL %s timeout waiting for DUT", tag);
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic settle();
      enable = 1'b0;
      ready  = 1'b1;
      repeat (10) tick();
   endtask

   // k-th beat of a burst, straight from the pattern definitions.
   function automatic logic [7:0] model_beat(input logic [1:0] m, input logic [7:0] sd,
                                             input logic [7:0] st, input int k);
      logic [7:0] v;
      case (m)
         2'd0: return 8'(int'(sd) + k * int'(st));
         2'd1: begin
            v = (sd == 8'h00) ? 8'h01 : sd;
            for (int i = 0; i < k; i++) v = (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
            return v;
         end
         2'd2: return 8'(1 << (k % 8));
         default: return sd;
      endcase
   endfunction

   // Checks one whole burst beat by beat; ready_mode 0=always, 1=toggle, 2=random.
   task automatic run_burst(input bit sel3, input logic [1:0] m, input logic [7:0] sd,
                            input logic [7:0] st, input int len, input int ready_mode,
                            input bit start, input bit hold, input string tag);
      int k   = 0;
      int cyc = 0;
      bit r;
      if (start) begin
         mode      = m;
         seed      = sd;
         step      = st;
         burst_len = 8'(len);
         enable    = 1'b1;
         tick();
      end
      while (k <= len && cyc < 200) begin
         if (!hold) enable = 1'b0;
         case (ready_mode)
            0:       r = 1'b1;
            1:       r = (cyc % 2 == 0);
            default: r = 1'($urandom_range(0, 1));
         endcase
         ready = r;
         check({tag, "_valid"}, 32'(sel3 ? valid3 : valid0), 32'(1));
         check({tag, "_data"},  32'(sel3 ? data3 : data0),   32'(model_beat(m, sd, st, k)));
         check({tag, "_last"},  32'(sel3 ? last3 : last0),   32'(k == len));
         if (r) k++;
         cyc++;
         tick();
      end
      if (k <= len) timeout_fail(tag);
   endtask

   initial begin
      int n;
      areset    = 1'b1;
      enable    = 1'b0;
      mode      = 2'd0;
      seed      = 8'h00;
      step      = 8'h00;
      burst_len = 8'h00;
      ready     = 1'b0;
      repeat (2) tick();
      check("rst_valid", 32'(valid0), 32'(0));
      check("rst_last",  32'(last0),  32'(0));
      check("rst_busy",  32'(busy0),  32'(0));
      check("rst_data",  32'(data0),  32'(0));
      check("rst_busy3", 32'(busy3),  32'(0));
      areset = 1'b0;
      settle();

      // COUNT wrapping through 0xFF, then back to IDLE.
      run_burst(1'b0, 2'd0, 8'hFE, 8'h01, 3, 0, 1'b1, 1'b0, "count");
      check("count_idle_busy",  32'(busy0),  32'(0));
      check("count_idle_valid", 32'(valid0), 32'(0));
      settle();

      // LFSR from seed 1, then the zero-seed lockup substitution.
      run_burst(1'b0, 2'd1, 8'h01, 8'h00, 5, 0, 1'b1, 1'b0, "lfsr");
      settle();
      run_burst(1'b0, 2'd1, 8'h00, 8'h00, 0, 0, 1'b1, 1'b0, "lfsr0");
      settle();

      // WALK with ready toggling: values must hold while stalled.
      run_burst(1'b0, 2'd2, 8'h77, 8'h00, 8, 1, 1'b1, 1'b0, "walk");
      settle();

      // CONST with a 3-cycle gap and enable held: 4 idle cycles between bursts.
      run_burst(1'b1, 2'd3, 8'h5A, 8'h00, 2, 0, 1'b1, 1'b1, "const1");
      n = 0;
      while (valid3 == 1'b0 && n < 20) begin
         n++;
         tick();
      end
      check("const_gap_len", 32'(n), 32'(4));
      run_burst(1'b1, 2'd3, 8'h5A, 8'h00, 2, 0, 1'b0, 1'b0, "const2");
      check("const_gap_busy", 32'(busy3), 32'(1));
      repeat (3) tick();
      check("const_end_busy",  32'(busy3),  32'(0));
      repeat (3) tick();
      check("const_stay_busy",  32'(busy3),  32'(0));
      check("const_stay_valid", 32'(valid3), 32'(0));
      settle();

      // Back-to-back bursts with no gap: valid must not drop across the boundary.
      run_burst(1'b0, 2'd0, 8'h10, 8'h02, 1, 0, 1'b1, 1'b1, "b2b1");
      run_burst(1'b0, 2'd0, 8'h10, 8'h02, 1, 0, 1'b0, 1'b1, "b2b2");
      run_burst(1'b0, 2'd0, 8'h10, 8'h02, 1, 0, 1'b0, 1'b0, "b2b3");
      check("b2b_end_busy", 32'(busy0), 32'(0));
      settle();

      // Asynchronous reset during the second beat, then restart from seed.
      mode      = 2'd0;
      seed      = 8'h33;
      step      = 8'h05;
      burst_len = 8'd4;
      enable    = 1'b1;
      ready     = 1'b1;
      tick();
      tick();
      check("rst_mid_data_pre", 32'(data0), 32'(model_beat(2'd0, 8'h33, 8'h05, 1)));
      areset = 1'b1;
      #1;
      check("rst_mid_valid", 32'(valid0), 32'(0));
      check("rst_mid_last",  32'(last0),  32'(0));
      check("rst_mid_data",  32'(data0),  32'(0));
      check("rst_mid_busy",  32'(busy0),  32'(0));
      tick();
      areset = 1'b0;
      run_burst(1'b0, 2'd0, 8'h33, 8'h05, 4, 0, 1'b1, 1'b0, "restart");
      settle();

      // Randomized bursts with random backpressure.
      for (int i = 0; i < 25; i++) begin
         logic [1:0] rm;
         logic [7:0] rs, rt;
         int         rl;
         rm = 2'($urandom_range(0, 3));
         rs = 8'($urandom_range(0, 255));
         rt = 8'($urandom_range(0, 255));
         rl = $urandom_range(0, 6);
         run_burst(1'b0, rm, rs, rt, rl, 2, 1'b1, 1'b0, "rand");
         check("rand_idle_busy", 32'(busy0), 32'(0));
         ready = 1'b1;
         repeat (4) tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
